ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

PS/2 host-to-device transmitter. It sends one command byte to the mouse, for example 0xF4 "enable data reporting" or 0xFF "reset", on the same ps2_clk/ps2_data pair that MouseCtl receives on. It runs in the 100 MHz domain next to MouseCtl. It performs the bus inhibit, request-to-send, bit shifting on device clock edges, and ACK check, and reports done or error.

## Interface
Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- INHIBIT_US, 100, time the clock line is held low before request-to-send.
- REQ_TIMEOUT_US, 15_000, maximum wait for the first device falling edge after the clock line is released.
- FRAME_TIMEOUT_US, 2_000, maximum time from the first device falling edge to ACK.

Ports:
- clk, input, 1, system clock. Reset is synchronous and active-high.
- rst, input, 1, synchronous active-high reset.
- ps2_clk_i, input, 1, raw PS/2 clock line (asynchronous).
- ps2_data_i, input, 1, raw PS/2 data line (asynchronous).
- ps2_clk_oe, output, 1, 1 = drive the PS/2 clock line low, 0 = release it. The top level builds the open-drain tristate.
- ps2_data_oe, output, 1, 1 = drive the PS/2 data line low, 0 = release it.
- tx_data, input, 8, command byte. Sampled on the cycle tx_start is accepted.
- tx_start, input, 1, single-cycle request. Accepted only when busy = 0.
- busy, output, 1, high from the cycle after acceptance until done or err.
- done, output, 1, one-cycle pulse: frame sent and ACK received.
- err, output, 1, one-cycle pulse: timeout or missing ACK.

## Operation
- Input synchroniser: ps2_clk_i and ps2_data_i each pass through a 2-flop synchroniser. A falling edge (fe) means the previous synchronised clock was 1 and the current one is 0.
- Frame: {stop=1, parity, d7..d0, start=0}, shifted LSB first. Parity is odd: parity = ~^tx_data.
- States:
  - IDLE: both oe = 0. tx_start loads the shift register and goes to INHIBIT.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYC cycles. In the last cycle, data_oe is set to 1 (start bit) and the next state is REQ.
  - REQ: clk_oe = 0, data_oe = 1. The first fe goes to SHIFT with bit_cnt = 0. A timeout goes to ERR.
  - SHIFT: on each fe, data_oe = ~shift[bit_cnt] for d0..d7 and parity. At bit_cnt = 9 (stop), data_oe = 0. After the stop-bit fe the next state is ACK.
  - ACK: on the next fe, sample data. 0 goes to WAIT_IDLE; 1 goes to ERR.
  - WAIT_IDLE: wait until synchronised clk and data are both 1, then go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
  - ERR: both oe = 0, err = 1 for one cycle, then IDLE.
- Cycle constants:
  - INHIBIT_CYC = CLK_FREQ_HZ/1_000_000*INHIBIT_US.
  - Timeout constants are computed the same way.
  - Counter width is $clog2 of the largest constant.
- The frame timeout runs through SHIFT, ACK and WAIT_IDLE. On expiry: both lines are released and the next state is ERR.
- tx_start while busy = 1 is ignored. It is not queued.
- done and err are never high together.

## Timing
- Reset values: ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0, done = 0, err = 0, state = IDLE, counters = 0.
- rst mid-frame: both lines are released on the first clock edge with rst high. No err pulse is produced.
- With tx_start accepted at cycle N:
  - clk_oe = 1 and busy = 1 at N+1.
  - data_oe = 1 at N+INHIBIT_CYC.
  - clk_oe = 0 at N+INHIBIT_CYC+1.
- Each data_oe update is registered. It changes 3 cycles after the raw falling edge (2 synchroniser flops plus the output register). This is far inside the device's half-period of at least 30 µs.
- All outputs are registered. There is no combinational path from the ps2 inputs to the outputs.

## Structure
- Package ps2_pkg holds:
  - state enum ps2_tx_state_t;
  - command constants PS2_CMD_RESET = 8'hFF, PS2_CMD_ENABLE = 8'hF4, PS2_CMD_DEFAULTS = 8'hF6;
  - PS2_ACK = 8'hFA (used by callers).
- Sub-module ps2_sync_edge: 2-flop synchroniser plus falling-edge pulse. It is instantiated once per line and is reusable by other PS/2 blocks.

## Test plan
- Send tx_data = 0xF4 with a bus-functional device model at 12.5 kHz:
  - clk_oe is low for exactly 10_000 cycles.
  - The model decodes bits 0,0,1,0,1,1,1,1, parity 0 and stop 1.
  - The model ACKs, and done pulses once after the lines go idle.
- Send 0xFF and 0x00: the model sees parity 1 in both cases, and done pulses.
- The model never clocks after request-to-send: err pulses 1_500_000 cycles after clk_oe falls, both oe = 0, busy = 0.
- The model holds data high in the ACK slot: err pulses on the 11th fe and done stays 0.
- tx_start again during SHIFT with 0x00: it is ignored and the transmitted byte remains the original 0xF4.
- rst asserted at the 5th fe: both oe = 0 on the next cycle, no err pulse. A subsequent 0xF6 completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, common mouse
// command bytes and a small helper for sizing cycle counters.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_DEFAULTS = 8'hF6;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge pulse
// derived from the synchronised value.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic fe
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Reset to the idle (released, pulled-up) level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign sync = sync_reg;
    assign fe   = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, data
// shifting on device falling edges, ACK check, done/err reporting.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 100_000_000,
    parameter int INHIBIT_US       = 100,
    parameter int REQ_TIMEOUT_US   = 15_000,
    parameter int FRAME_TIMEOUT_US = 2_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int REQ_CYC     = CLK_FREQ_HZ / 1_000_000 * REQ_TIMEOUT_US;
    localparam int FRAME_CYC   = CLK_FREQ_HZ / 1_000_000 * FRAME_TIMEOUT_US;
    localparam int CNT_W       = $clog2(max3(INHIBIT_CYC, REQ_CYC, FRAME_CYC));

    logic [1:0] line_raw;
    logic [1:0] line_sync;
    logic [1:0] line_fe;

    assign line_raw = {ps2_data_i, ps2_clk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            ps2_sync_edge u_sync (
                .clk  (clk),
                .rst  (rst),
                .din  (line_raw[gi]),
                .sync (line_sync[gi]),
                .fe   (line_fe[gi])
            );
        end
    endgenerate

    logic clk_sync;
    logic clk_fe;
    logic data_sync;
    logic unused_data_fe;

    assign clk_sync       = line_sync[0];
    assign clk_fe         = line_fe[0];
    assign data_sync      = line_sync[1];
    assign unused_data_fe = line_fe[1];

    ps2_tx_state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [8:0]       shift_reg, shift_next;
    logic             clk_oe_reg, clk_oe_next;
    logic             data_oe_reg, data_oe_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [3:0]       bit_inc;

    assign bit_inc = bit_cnt_reg + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            clk_oe_reg  <= clk_oe_next;
            data_oe_reg <= data_oe_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        clk_oe_next  = clk_oe_reg;
        data_oe_next = data_oe_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            IDLE, DONE, ERR: begin
                // DONE/ERR already report busy = 0, so a new request is taken here too.
                state_next   = IDLE;
                cnt_next     = '0;
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                if (tx_start) begin
                    shift_next  = {~^tx_data, tx_data};
                    clk_oe_next = 1'b1;
                    state_next  = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(INHIBIT_CYC - 2)) begin
                    data_oe_next = 1'b1;
                end
                if (cnt_reg == CNT_W'(INHIBIT_CYC - 1)) begin
                    data_oe_next = 1'b1;
                    clk_oe_next  = 1'b0;
                    cnt_next     = '0;
                    state_next   = REQ;
                end
            end
            REQ: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (clk_fe) begin
                    // The first device falling edge already calls for d0.
                    data_oe_next = ~shift_reg[0];
                    bit_cnt_next = 4'd0;
                    cnt_next     = '0;
                    state_next   = SHIFT;
                end else if (cnt_reg == CNT_W'(REQ_CYC - 1)) begin
                    clk_oe_next  = 1'b0;
                    data_oe_next = 1'b0;
                    err_next     = 1'b1;
                    state_next   = ERR;
                end
            end
            SHIFT, ACK, WAIT_IDLE: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(FRAME_CYC - 1)) begin
                    clk_oe_next  = 1'b0;
                    data_oe_next = 1'b0;
                    err_next     = 1'b1;
                    state_next   = ERR;
                end else if (state_reg == SHIFT) begin
                    if (clk_fe) begin
                        bit_cnt_next = bit_inc;
                        if (bit_cnt_reg == 4'd8) begin
                            data_oe_next = 1'b0;
                            state_next   = ACK;
                        end else begin
                            data_oe_next = ~shift_reg[bit_inc];
                        end
                    end
                end else if (state_reg == ACK) begin
                    if (clk_fe) begin
                        if (!data_sync) begin
                            state_next = WAIT_IDLE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = ERR;
                        end
                    end
                end else begin
                    if (clk_sync && data_sync) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
            end
        endcase

        busy_next = (state_next != IDLE) && (state_next != DONE) && (state_next != ERR);
    end

    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx with a behavioural PS/2 device model
// driving the open-drain lines; one line printed per transaction.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ    = 2_000_000;
    localparam int INH_US    = 100;
    localparam int REQ_US    = 2_000;
    localparam int FRM_US    = 1_000;
    localparam int INH_CYC   = CLK_HZ / 1_000_000 * INH_US;
    localparam int REQ_CYC   = CLK_HZ / 1_000_000 * REQ_US;

    localparam int M_NORMAL  = 0;
    localparam int M_NOCLK   = 1;
    localparam int M_NACK    = 2;
    localparam int M_RESTART = 3;
    localparam int M_RESET   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       ps2_clk_line, ps2_data_line;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int err_seen = 0;
    logic both_seen = 1'b0;

    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_FREQ_HZ      (CLK_HZ),
        .INHIBIT_US       (INH_US),
        .REQ_TIMEOUT_US   (REQ_US),
        .FRAME_TIMEOUT_US (FRM_US)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_i   (ps2_clk_line),
        .ps2_data_i  (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always @(posedge clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
        if (err === 1'b1) err_seen <= err_seen + 1;
        if (done === 1'b1 && err === 1'b1) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device side of one command transfer; the device reads on rising edges.
    task automatic run_frame(input logic [7:0] b, input int mode, input int half);
        int d0, e0, k, dt, j;
        logic [9:0] bits;
        logic exp_par;
        $display("tx byte=%02h mode=%0d half=%0d", b, mode, half);
        exp_par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        d0 = done_seen;
        e0 = err_seen;
        bits = '0;

        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        chk("busy_after_start", 32'(busy), 1);
        chk("clk_oe_after_start", 32'(ps2_clk_oe), 1);

        k  = 1;
        dt = 0;
        while (ps2_clk_oe === 1'b1 && k < INH_CYC + 50) begin
            if (ps2_data_oe === 1'b1 && dt == 0) dt = k;
            k++;
            @(negedge clk);
        end
        chk("inhibit_len", 32'(k - 1), 32'(INH_CYC));
        chk("start_bit_cycle", 32'(dt), 32'(INH_CYC));
        chk("req_data_low", 32'(ps2_data_oe), 1);

        if (mode == M_NOCLK) begin
            j = 0;
            while (err !== 1'b1 && j < REQ_CYC + 50) begin
                @(negedge clk);
                j++;
            end
            chk("req_timeout_cycles", 32'(j), 32'(REQ_CYC));
            chk("req_timeout_clk_oe", 32'(ps2_clk_oe), 0);
            chk("req_timeout_data_oe", 32'(ps2_data_oe), 0);
            chk("req_timeout_busy", 32'(busy), 0);
            tick(5);
            chk("req_timeout_no_done", 32'(done_seen - d0), 0);
            return;
        end

        tick(half);
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            if (mode == M_RESET && i == 5) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
                chk("rst_data_oe", 32'(ps2_data_oe), 0);
                chk("rst_busy", 32'(busy), 0);
                dev_clk = 1'b1;
                tick(50);
                chk("rst_no_err", 32'(err_seen - e0), 0);
                chk("rst_no_done", 32'(done_seen - d0), 0);
                return;
            end
            if (mode == M_RESTART && i == 4) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                tick(half - 1);
            end else begin
                tick(half);
            end
            dev_clk = 1'b1;
            tick(half / 2);
            bits[i-1] = ps2_data_line;
            tick(half - half / 2);
        end
        chk("data_byte", 32'(bits[7:0]), 32'(b));
        chk("parity_bit", 32'(bits[8]), 32'(exp_par));
        chk("stop_bit", 32'(bits[9]), 1);

        if (mode != M_NACK) dev_data = 1'b0;
        tick(half / 2);
        dev_clk = 1'b0;
        tick(half);
        if (mode == M_NACK) chk("nack_err_at_fe11", 32'(err_seen - e0), 1);
        dev_clk = 1'b1;
        tick(half / 2);
        if (mode != M_NACK) chk("no_done_before_idle", 32'(done_seen - d0), 0);
        dev_data = 1'b1;
        j = 0;
        while (done_seen == d0 && err_seen == e0 && j < 100) begin
            @(negedge clk);
            j++;
        end
        tick(3);
        chk("done_count", 32'(done_seen - d0), (mode == M_NACK) ? 0 : 1);
        chk("err_count", 32'(err_seen - e0), (mode == M_NACK) ? 1 : 0);
        chk("busy_end", 32'(busy), 0);
        chk("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    endtask

    initial begin
        tick(5);
        chk("reset_clk_oe", 32'(ps2_clk_oe), 0);
        chk("reset_data_oe", 32'(ps2_data_oe), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        rst = 1'b0;
        tick(5);

        run_frame(PS2_CMD_ENABLE, M_NORMAL, 30);
        run_frame(PS2_CMD_RESET, M_NORMAL, 25);
        run_frame(8'h00, M_NORMAL, 35);
        for (int r = 0; r < 4; r++) begin
            run_frame(8'($urandom), M_NORMAL, 20 + int'($urandom_range(0, 20)));
        end
        run_frame(PS2_CMD_ENABLE, M_NOCLK, 30);
        run_frame(PS2_CMD_ENABLE, M_NACK, 30);
        run_frame(PS2_CMD_ENABLE, M_RESTART, 30);
        run_frame(PS2_CMD_ENABLE, M_RESET, 30);
        run_frame(PS2_CMD_DEFAULTS, M_NORMAL, 30);

        chk("done_err_exclusive", 32'(both_seen), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
